// File: rtl/mem_to_uart_if.sv
// BRAM port B and UART TX signal bundle for the memory read-back path.
// The master side (mem_to_uart) drives address/enable and the TX byte; the slave side
// (BRAM + UART TX) returns read data and the TX busy flag.
interface mem_to_uart_if;
  logic [31:0] doutB;
  logic [31:0] addrB;
  logic        enB;
  logic [3:0]  weB;
  logic [7:0]  uart_data;
  logic        uart_send;
  logic        uart_busy;

  modport master (
    input  doutB, uart_busy,
    output addrB, enB, weB, uart_data, uart_send
  );

  modport slave (
    output doutB, uart_busy,
    input  addrB, enB, weB, uart_data, uart_send
  );
endinterface

// File: rtl/mem_to_uart.sv
// Reads NUM_WORDS words from BRAM port B and streams each as 4 bytes, LSB first, to a UART TX.
// Handshake: uart_send is a 1-cycle strobe issued only while uart_busy=0; uart_data is valid
// with it and held until the TX drops uart_busy again.
module mem_to_uart #(
  parameter int NUM_WORDS    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state_o,
  mem_to_uart_if.master bus
);

  localparam int              WIDX      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WIDX-1:0] LAST_WORD = WIDX'(NUM_WORDS - 1);
  localparam logic [1:0]      LAT_LOAD  = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_RD_WAIT = 3'd2,
    S_SEND    = 3'd3,
    S_GAP     = 3'd4,
    S_TX_WAIT = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [WIDX-1:0] word_idx_q, word_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [31:0]     word_reg_q, word_reg_d;
  logic [1:0]      lat_q, lat_d;
  logic [7:0]      uart_data_q, uart_data_d;
  logic [1:0]      byte_nxt;
  logic            en_b;
  logic            send;

  assign byte_nxt = byte_idx_q + 2'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      word_reg_q  <= '0;
      lat_q       <= '0;
      uart_data_q <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      word_reg_q  <= word_reg_d;
      lat_q       <= lat_d;
      uart_data_q <= uart_data_d;
    end
  end

  // uart_data is loaded on entry to SEND so it is already stable when the strobe fires.
  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    word_reg_d  = word_reg_q;
    lat_d       = lat_q;
    uart_data_d = uart_data_q;
    en_b        = 1'b0;
    send        = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          word_idx_d = '0;
          byte_idx_d = '0;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        en_b    = 1'b1;
        lat_d   = LAT_LOAD;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        en_b = 1'b1;
        if (lat_q == 2'd0) begin
          word_reg_d  = bus.doutB;
          uart_data_d = bus.doutB[{byte_idx_q, 3'b000} +: 8];
          state_d     = S_SEND;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      S_SEND: begin
        if (!bus.uart_busy) begin
          send    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (!bus.uart_busy) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d  = byte_nxt;
            uart_data_d = word_reg_q[{byte_nxt, 3'b000} +: 8];
            state_d     = S_SEND;
          end else if (word_idx_q != LAST_WORD) begin
            byte_idx_d = '0;
            word_idx_d = word_idx_q + 1'b1;
            state_d    = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.addrB     = 32'({word_idx_q, 2'b00});
  assign bus.enB       = en_b;
  assign bus.weB       = 4'h0;
  assign bus.uart_data = uart_data_q;
  assign bus.uart_send = send;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_to_uart.sv
// Bench for mem_to_uart: BRAM + UART TX models, byte-stream scoreboard built from memory
// contents, one negedge compare process, and directed scenarios with randomized data/timing.
module tb_mem_to_uart;
  localparam int NW  = 8;
  localparam int NW2 = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic busy, done, busy2, done2;
  logic [2:0] st, st2;

  always #5 clock = ~clock;

  mem_to_uart_if bus ();
  mem_to_uart_if bus2 ();

  mem_to_uart #(.NUM_WORDS(NW), .READ_LATENCY(1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .dbg_state_o(st), .bus(bus)
  );

  mem_to_uart #(.NUM_WORDS(NW2), .READ_LATENCY(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
    .dbg_state_o(st2), .bus(bus2)
  );

  // BRAM models: 1-stage and 2-stage registered reads
  logic [31:0] mem [NW];
  logic [31:0] mem2 [NW2];
  logic [31:0] rd1 = '0, rd2a = '0, rd2b = '0;
  always @(posedge clock) begin
    if (bus.enB) rd1 <= mem[bus.addrB[4:2]];
    if (bus2.enB) rd2a <= mem2[bus2.addrB[2]];
    rd2b <= rd2a;
  end
  assign bus.doutB  = rd1;
  assign bus2.doutB = rd2b;

  // UART TX models: busy from the cycle after uart_send for tx_len cycles
  int   tx_cnt = 0, tx_len = 10, tx2_cnt = 0;
  logic hold_busy = 1'b0;
  always @(posedge clock) begin
    if (bus.uart_send) tx_cnt <= tx_len;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    if (bus2.uart_send) tx2_cnt <= 3;
    else if (tx2_cnt > 0) tx2_cnt <= tx2_cnt - 1;
  end
  assign bus.uart_busy  = (tx_cnt > 0) || hold_busy;
  assign bus2.uart_busy = (tx2_cnt > 0);

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];
  logic [7:0] log_q[$];
  logic [7:0] log2_q[$];
  int   tests = 0, fails = 0;
  int   sent = 0, sent2 = 0, done_cnt = 0, done2_cnt = 0;
  int   cyc = 0, rd_start = 0, rd2_start = 0;
  logic done_prev = 1'b0, done2_prev = 1'b0, en_prev = 1'b0, en2_prev = 1'b0;
  logic hold_phase = 1'b0;
  logic [7:0] last_byte = '0, e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (reset_n) begin
      chk("weB", 32'(bus.weB), 32'h0);
      if (bus.enB && !en_prev) rd_start = cyc;
      if (bus.uart_send) begin
        chk("send_while_busy", 32'(bus.uart_busy), 32'h0);
        if (sent % 4 == 0 && !hold_phase) chk("read_to_send_lat", 32'(cyc - rd_start), 32'd2);
        if (exp_q.size() == 0) chk("extra_send", 32'(sent), 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("uart_data", 32'(bus.uart_data), 32'(e));
        end
        log_q.push_back(bus.uart_data);
        last_byte = bus.uart_data;
        sent++;
      end else if (tx_cnt > 0) begin
        chk("data_hold", 32'(bus.uart_data), 32'(last_byte));
      end
      if (bus.enB) chk("addrB", bus.addrB, 32'(4 * (sent / 4)));
      if (done && !done_prev) begin
        done_cnt++;
        chk("done_bytes", 32'(sent), 32'(4 * NW));
        chk("done_busy_low", 32'(bus.uart_busy), 32'h0);
      end
      if (done && busy) chk("done_and_busy", 32'h1, 32'h0);

      chk("weB2", 32'(bus2.weB), 32'h0);
      if (bus2.enB && !en2_prev) rd2_start = cyc;
      if (bus2.uart_send) begin
        if (sent2 % 4 == 0) chk("read_to_send_lat2", 32'(cyc - rd2_start), 32'd3);
        if (exp2_q.size() == 0) chk("extra_send2", 32'(sent2), 32'hFFFF);
        else begin
          e = exp2_q.pop_front();
          chk("uart_data2", 32'(bus2.uart_data), 32'(e));
        end
        log2_q.push_back(bus2.uart_data);
        sent2++;
      end
      if (bus2.enB) chk("addrB2", bus2.addrB, 32'(4 * (sent2 / 4)));
      if (done2 && !done2_prev) begin
        done2_cnt++;
        chk("done2_bytes", 32'(sent2), 32'(4 * NW2));
      end
    end
    done_prev  = done;
    done2_prev = done2;
    en_prev    = bus.enB;
    en2_prev   = bus2.enB;
  end

  task automatic begin_dump();
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < 4; b++) exp_q.push_back(mem[w][8*b +: 8]);
    sent = 0;
    log_q.delete();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'h1);
    chk("done_drops", 32'(done), 32'h0);
  endtask

  task automatic finish_dump(input int dc0);
    int budget = 0;
    while (!(done && exp_q.size() == 0) && budget < 5000) begin
      @(negedge clock);
      budget++;
    end
    chk("dump_timeout", 32'(budget < 5000), 32'h1);
    @(negedge clock);
    chk("done_count", 32'(done_cnt), 32'(dc0 + 1));
    chk("sent_total", 32'(sent), 32'(4 * NW));
    chk("done_final", 32'(done), 32'h1);
    chk("busy_final", 32'(busy), 32'h0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < NW; i++) mem[i] = $urandom();
  endtask

  initial begin
    int dc0;
    int budget;
    for (int i = 0; i < NW; i++) mem[i] = 32'h03020100 + 32'h04040404 * i;
    mem2[0] = 32'hDEADBEEF;
    mem2[1] = $urandom();

    // reset values
    @(negedge clock);
    chk("rst_enB", 32'(bus.enB), 32'h0);
    chk("rst_addrB", bus.addrB, 32'h0);
    chk("rst_uart_data", 32'(bus.uart_data), 32'h0);
    chk("rst_uart_send", 32'(bus.uart_send), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_enB2", 32'(bus2.enB), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // incrementing pattern, TX busy 10 clocks
    dc0 = done_cnt;
    begin_dump();
    finish_dump(dc0);
    chk("pin_byte0", 32'(log_q[0]), 32'h00);
    chk("pin_byte5", 32'(log_q[5]), 32'h05);
    chk("pin_byte31", 32'(log_q[31]), 32'h1F);

    // restart from DONE with identical contents
    dc0 = done_cnt;
    begin_dump();
    finish_dump(dc0);
    chk("rerun_byte17", 32'(log_q[17]), 32'h11);
    chk("rerun_byte31", 32'(log_q[31]), 32'h1F);

    // 2-cycle read latency instance
    for (int w = 0; w < NW2; w++)
      for (int b = 0; b < 4; b++) exp2_q.push_back(mem2[w][8*b +: 8]);
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    budget = 0;
    while (!(done2 && exp2_q.size() == 0) && budget < 2000) begin
      @(negedge clock);
      budget++;
    end
    chk("dump2_timeout", 32'(budget < 2000), 32'h1);
    @(negedge clock);
    chk("pin2_b0", 32'(log2_q[0]), 32'hEF);
    chk("pin2_b1", 32'(log2_q[1]), 32'hBE);
    chk("pin2_b2", 32'(log2_q[2]), 32'hAD);
    chk("pin2_b3", 32'(log2_q[3]), 32'hDE);
    chk("done2_count", 32'(done2_cnt), 32'h1);

    // TX already busy when the dump starts
    randomize_mem();
    tx_len = $urandom_range(1, 12);
    hold_busy = 1'b1;
    hold_phase = 1'b1;
    dc0 = done_cnt;
    begin_dump();
    repeat (40) @(negedge clock);
    chk("no_send_while_held", 32'(sent), 32'h0);
    hold_busy = 1'b0;
    finish_dump(dc0);
    hold_phase = 1'b0;

    // start pulsed mid-dump is ignored
    randomize_mem();
    tx_len = $urandom_range(1, 12);
    dc0 = done_cnt;
    begin_dump();
    budget = 0;
    while (sent < 5 && budget < 2000) begin
      @(negedge clock);
      budget++;
    end
    chk("reach_byte5", 32'(budget < 2000), 32'h1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    finish_dump(dc0);

    // reset in the middle of word 3
    randomize_mem();
    tx_len = 12;
    begin_dump();
    budget = 0;
    while (!(sent == 14 && tx_cnt > 2) && budget < 3000) begin
      @(negedge clock);
      budget++;
    end
    chk("reach_word3", 32'(budget < 3000), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_enB", 32'(bus.enB), 32'h0);
    chk("mid_rst_addrB", bus.addrB, 32'h0);
    chk("mid_rst_send", 32'(bus.uart_send), 32'h0);
    chk("mid_rst_data", 32'(bus.uart_data), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    exp_q.delete();
    log_q.delete();
    sent = 0;
    last_byte = '0;
    repeat (15) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    randomize_mem();
    dc0 = done_cnt;
    begin_dump();
    finish_dump(dc0);
    chk("after_rst_byte0", 32'(log_q[0]), 32'(mem[0][7:0]));

    // a few more random runs
    for (int r = 0; r < 2; r++) begin
      randomize_mem();
      tx_len = $urandom_range(1, 12);
      repeat ($urandom_range(0, 5)) @(negedge clock);
      dc0 = done_cnt;
      begin_dump();
      finish_dump(dc0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
